mux_select_sequencer: RTL and testbench

- Upstream control stage for mux_8to1_1bit.
- Walks the 3-bit dual-rail Select/_Select pair through all eight mux inputs and waits a settle interval at each.
- Samples the mux Out back in (MuxOut) and presents each bit downstream with a valid/ready handshake.
- Serialises eight parallel mux inputs onto one handshaked bit stream, then pulses Done.

---
 rtl/mux_select_sequencer_pkg.sv | 43 ++++
 rtl/mux_select_sequencer_if.sv | 40 ++++
 rtl/dual_rail_sel_reg.sv | 38 +++
 rtl/mux_select_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_mux_select_sequencer.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_select_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mux_select_sequencer_pkg
// Shared definitions for the mux select sequencer and its dual-rail select
// register: FSM state encodings, rail reset constants, counter width and the
// small index helpers used to walk the eight mux inputs in either order.
// -----------------------------------------------------------------------------
package mux_select_sequencer_pkg;

  // Width of the mux select and of the settle counter.
  localparam int SEL_W = 3;
  localparam int CNT_W = 4;

  // Rail values after reset: true rail low, complement rail high.
  localparam logic [SEL_W-1:0] SEL_RESET  = 3'b000;
  localparam logic [SEL_W-1:0] NSEL_RESET = 3'b111;

  localparam logic [CNT_W-1:0] CNT_ZERO = 4'd0;
  localparam logic [CNT_W-1:0] CNT_ONE  = 4'd1;

  typedef enum logic [1:0] {
    SEQ_IDLE    = 2'd0,
    SEQ_SETTLE  = 2'd1,
    SEQ_PRESENT = 2'd2,
    SEQ_DONE    = 2'd3
  } seq_state_t;

  // First mux input visited by a scan.
  function automatic logic [SEL_W-1:0] first_index(input logic msb_first);
    return msb_first ? 3'd7 : 3'd0;
  endfunction

  // Final mux input of a scan; reaching it ends the scan, so the index never wraps.
  function automatic logic [SEL_W-1:0] last_index(input logic msb_first);
    return msb_first ? 3'd0 : 3'd7;
  endfunction

  // Next mux input in scan order.
  function automatic logic [SEL_W-1:0] step_index(input logic [SEL_W-1:0] idx,
                                                  input logic msb_first);
    return msb_first ? (idx - 3'd1) : (idx + 3'd1);
  endfunction

endpackage

// File: rtl/mux_select_sequencer_if.sv
// -----------------------------------------------------------------------------
// mux_select_sequencer_if
// Bundles the sequencer's control, mux and downstream handshake signals.
//   start     : request one 8-bit scan
//   muxout    : Out of the downstream mux_8to1_1bit
//   select    : true-rail mux select
//   select_n  : complement-rail mux select (always ~select)
//   bitout    : sampled mux bit
//   bitindex  : mux input number bitout came from
//   bitvalid  : bitout/bitindex valid
//   bitready  : downstream accepts when bitvalid && bitready
//   busy      : sequencer not idle
//   done      : one-cycle pulse at the end of a scan
// master = sequencer side, slave = environment (controller, mux, consumer).
// -----------------------------------------------------------------------------
interface mux_select_sequencer_if;
  import mux_select_sequencer_pkg::*;

  logic             start;
  logic             muxout;
  logic [SEL_W-1:0] select;
  logic [SEL_W-1:0] select_n;
  logic             bitout;
  logic [SEL_W-1:0] bitindex;
  logic             bitvalid;
  logic             bitready;
  logic             busy;
  logic             done;

  modport master (
    input  start, muxout, bitready,
    output select, select_n, bitout, bitindex, bitvalid, busy, done
  );

  modport slave (
    output start, muxout, bitready,
    input  select, select_n, bitout, bitindex, bitvalid, busy, done
  );

endinterface

// File: rtl/dual_rail_sel_reg.sv
// -----------------------------------------------------------------------------
// dual_rail_sel_reg
// Dual-rail select register for a dual-rail mux. Both rails are separate
// flops loaded on the same edge from one value, so they can never disagree
// and never read all-zero/all-zero or all-one/all-one.
//   clk   : clock
//   reset : synchronous, active-high
//   load  : capture d into both rails
//   d     : new select value
//   q     : true rail
//   qn    : complement rail
// -----------------------------------------------------------------------------
module dual_rail_sel_reg
  import mux_select_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [SEL_W-1:0] d,
  output logic [SEL_W-1:0] q,
  output logic [SEL_W-1:0] qn
);

  // Rail registers: reset to the complementary pair, then load both together.
  always_ff @(posedge clk) begin
    if (reset) begin
      q  <= SEL_RESET;
      qn <= NSEL_RESET;
    end else if (load) begin
      q  <= d;
      qn <= ~d;
    end else begin
      q  <= q;
      qn <= qn;
    end
  end

endmodule

// File: rtl/mux_select_sequencer.sv
// -----------------------------------------------------------------------------
// mux_select_sequencer
// Walks a dual-rail select through all eight inputs of a mux_8to1_1bit,
// waits SETTLE_CYCLES at each, samples the mux output on the last settle
// cycle and hands each bit downstream over a valid/ready handshake. After
// the eighth bit is accepted, done pulses for one cycle.
//   clock : single clock, rising edge
//   reset : synchronous, active-high; abandons any scan in progress
//   bus   : mux_select_sequencer_if.master (start, muxout, select/select_n,
//           bitout/bitindex/bitvalid/bitready, busy, done)
// Parameters:
//   MSB_FIRST     : 0 visits In0..In7, 1 visits In7..In0
//   SETTLE_CYCLES : cycles select is held before sampling, 1..15
// -----------------------------------------------------------------------------
module mux_select_sequencer
  import mux_select_sequencer_pkg::*;
#(
  parameter bit          MSB_FIRST     = 1'b0,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  mux_select_sequencer_if.master bus
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [SEL_W-1:0] IDX_FIRST   = first_index(MSB_FIRST);
  localparam logic [SEL_W-1:0] IDX_LAST    = last_index(MSB_FIRST);

  seq_state_t       state_r;
  seq_state_t       state_nxt_s;
  logic [SEL_W-1:0] index_r;
  logic [SEL_W-1:0] index_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             bitout_r;
  logic             bitout_nxt_s;
  logic [SEL_W-1:0] bitindex_r;
  logic [SEL_W-1:0] bitindex_nxt_s;
  logic             bitvalid_r;
  logic             bitvalid_nxt_s;
  logic             busy_r;
  logic             done_r;
  logic             sel_load_s;
  logic [SEL_W-1:0] sel_d_s;
  logic             xfer_s;
  logic             settle_end_s;
  logic             last_s;

  assign xfer_s       = bitvalid_r & bus.bitready;
  assign settle_end_s = (cnt_r == CNT_ONE);
  assign last_s       = (index_r == IDX_LAST);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= SEQ_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      SEQ_IDLE: begin
        if (bus.start) begin
          state_nxt_s = SEQ_SETTLE;
        end else begin
          state_nxt_s = SEQ_IDLE;
        end
      end
      SEQ_SETTLE: begin
        if (settle_end_s) begin
          state_nxt_s = SEQ_PRESENT;
        end else begin
          state_nxt_s = SEQ_SETTLE;
        end
      end
      SEQ_PRESENT: begin
        if (xfer_s) begin
          state_nxt_s = last_s ? SEQ_DONE : SEQ_SETTLE;
        end else begin
          state_nxt_s = SEQ_PRESENT;
        end
      end
      SEQ_DONE: begin
        // start is deliberately not looked at here; a new scan needs an IDLE cycle.
        state_nxt_s = SEQ_IDLE;
      end
      default: begin
        state_nxt_s = SEQ_IDLE;
      end
    endcase
  end

  // Output/datapath next values; everything holds unless the state acts on it.
  always_comb begin
    index_nxt_s    = index_r;
    cnt_nxt_s      = cnt_r;
    bitout_nxt_s   = bitout_r;
    bitindex_nxt_s = bitindex_r;
    bitvalid_nxt_s = bitvalid_r;
    sel_load_s     = 1'b0;
    sel_d_s        = index_r;
    case (state_r)
      SEQ_IDLE: begin
        if (bus.start) begin
          index_nxt_s = IDX_FIRST;
          sel_load_s  = 1'b1;
          sel_d_s     = IDX_FIRST;
          cnt_nxt_s   = SETTLE_LOAD;
        end else begin
          index_nxt_s = index_r;
          sel_load_s  = 1'b0;
        end
      end
      SEQ_SETTLE: begin
        cnt_nxt_s = cnt_r - CNT_ONE;
        // muxout only matters on the final settle cycle.
        if (settle_end_s) begin
          bitout_nxt_s   = bus.muxout;
          bitindex_nxt_s = index_r;
          bitvalid_nxt_s = 1'b1;
        end else begin
          bitvalid_nxt_s = bitvalid_r;
        end
      end
      SEQ_PRESENT: begin
        if (xfer_s) begin
          bitvalid_nxt_s = 1'b0;
          if (!last_s) begin
            index_nxt_s = step_index(index_r, MSB_FIRST);
            sel_load_s  = 1'b1;
            sel_d_s     = step_index(index_r, MSB_FIRST);
            cnt_nxt_s   = SETTLE_LOAD;
          end else begin
            // Last input accepted: keep select where it is.
            sel_load_s = 1'b0;
          end
        end else begin
          bitvalid_nxt_s = bitvalid_r;
        end
      end
      SEQ_DONE: begin
        cnt_nxt_s = CNT_ZERO;
      end
      default: begin
        bitvalid_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath and status registers; busy/done follow the next state so they
  // line up with the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      index_r    <= SEL_RESET;
      cnt_r      <= CNT_ZERO;
      bitout_r   <= 1'b0;
      bitindex_r <= SEL_RESET;
      bitvalid_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      index_r    <= index_nxt_s;
      cnt_r      <= cnt_nxt_s;
      bitout_r   <= bitout_nxt_s;
      bitindex_r <= bitindex_nxt_s;
      bitvalid_r <= bitvalid_nxt_s;
      busy_r     <= (state_nxt_s != SEQ_IDLE);
      done_r     <= (state_nxt_s == SEQ_DONE);
    end
  end

  dual_rail_sel_reg u_sel (
    .clk   (clock),
    .reset (reset),
    .load  (sel_load_s),
    .d     (sel_d_s),
    .q     (bus.select),
    .qn    (bus.select_n)
  );

  assign bus.bitout   = bitout_r;
  assign bus.bitindex = bitindex_r;
  assign bus.bitvalid = bitvalid_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mux_select_sequencer
// Directed bench for mux_select_sequencer. Three instances cover
// LSB-first/settle 1, MSB-first/settle 1 and LSB-first/settle 3. Each mux
// is modelled as mux_in[select]; the settle-3 instance can have its muxout
// overridden to probe the sampling point.
// -----------------------------------------------------------------------------
module tb_mux_select_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] mux_in = 8'b1011_0010;
  logic       ovr_en;
  logic       ovr_val;
  bit         rail_en = 1'b0;
  int         checks = 0;
  int         failures = 0;

  // Hand-computed bit streams for mux_in = 1011_0010 (In7..In0).
  logic exp_lsb [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic exp_msb [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  mux_select_sequencer_if if0 ();
  mux_select_sequencer_if if1 ();
  mux_select_sequencer_if if3 ();

  assign if0.muxout = mux_in[if0.select];
  assign if1.muxout = mux_in[if1.select];
  assign if3.muxout = ovr_en ? ovr_val : mux_in[if3.select];

  mux_select_sequencer #(.MSB_FIRST(1'b0), .SETTLE_CYCLES(1)) dut0 (
    .clock(clk), .reset(reset), .bus(if0));
  mux_select_sequencer #(.MSB_FIRST(1'b1), .SETTLE_CYCLES(1)) dut1 (
    .clock(clk), .reset(reset), .bus(if1));
  mux_select_sequencer #(.MSB_FIRST(1'b0), .SETTLE_CYCLES(3)) dut3 (
    .clock(clk), .reset(reset), .bus(if3));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Complement rail must mirror the true rail on every cycle.
  always @(negedge clk) begin
    if (rail_en) begin
      check_eq("rails0", {29'd0, if0.select_n}, {29'd0, ~if0.select});
      check_eq("rails1", {29'd0, if1.select_n}, {29'd0, ~if1.select});
      check_eq("rails3", {29'd0, if3.select_n}, {29'd0, ~if3.select});
    end
  end

  initial begin
    int n, nb0, nb1, done_at0, done_at1, ndone0, ndone1, vfirst0;
    int first_done, second_done, ndone;
    bit found, seen_done;

    reset = 1'b1;
    ovr_en = 1'b0; ovr_val = 1'b0;
    if0.start = 1'b0; if1.start = 1'b0; if3.start = 1'b0;
    if0.bitready = 1'b0; if1.bitready = 1'b0; if3.bitready = 1'b0;
    tick(); tick();

    // Reset state
    check_eq("rst_sel",      {29'd0, if0.select},   32'd0);
    check_eq("rst_seln",     {29'd0, if0.select_n}, 32'd7);
    check_eq("rst_valid",    {31'd0, if0.bitvalid}, 32'd0);
    check_eq("rst_busy",     {31'd0, if0.busy},     32'd0);
    check_eq("rst_done",     {31'd0, if0.done},     32'd0);
    check_eq("rst_bitout",   {31'd0, if0.bitout},   32'd0);
    check_eq("rst_bitindex", {29'd0, if0.bitindex}, 32'd0);
    check_eq("rst_sel1",     {29'd0, if1.select},   32'd0);
    reset = 1'b0;
    rail_en = 1'b1;
    tick();

    // Full scans, LSB-first (dut0) and MSB-first (dut1), ready tied high
    if0.bitready = 1'b1; if1.bitready = 1'b1;
    if0.start = 1'b1; if1.start = 1'b1;
    nb0 = 0; nb1 = 0; done_at0 = 0; done_at1 = 0; ndone0 = 0; ndone1 = 0; vfirst0 = 0;
    tick(); n = 1;
    if0.start = 1'b0; if1.start = 1'b0;
    check_eq("scan_sel0_first", {29'd0, if0.select}, 32'd0);
    check_eq("scan_sel1_first", {29'd0, if1.select}, 32'd7);
    check_eq("scan_busy0",      {31'd0, if0.busy},   32'd1);
    while (n < 40) begin
      tick(); n++;
      if (if0.bitvalid) begin
        if (vfirst0 == 0) vfirst0 = n;
        if (nb0 < 8) begin
          check_eq("lsb_idx", {29'd0, if0.bitindex}, nb0);
          check_eq("lsb_bit", {31'd0, if0.bitout},   {31'd0, exp_lsb[nb0]});
        end
        nb0++;
      end
      if (if1.bitvalid) begin
        if (nb1 < 8) begin
          check_eq("msb_idx", {29'd0, if1.bitindex}, 7 - nb1);
          check_eq("msb_bit", {31'd0, if1.bitout},   {31'd0, exp_msb[nb1]});
        end
        nb1++;
      end
      if (if0.done) begin ndone0++; if (done_at0 == 0) done_at0 = n; end
      if (if1.done) begin ndone1++; if (done_at1 == 0) done_at1 = n; end
    end
    check_eq("lsb_nbits",   nb0,      32'd8);
    check_eq("msb_nbits",   nb1,      32'd8);
    check_eq("first_valid", vfirst0,  32'd2);
    check_eq("done_at0",    done_at0, 32'd17);
    check_eq("done_at1",    done_at1, 32'd17);
    check_eq("ndone0",      ndone0,   32'd1);
    check_eq("ndone1",      ndone1,   32'd1);

    // Backpressure at index 2
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (if0.bitvalid && if0.bitindex == 3'd2) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check_eq("stall_found", {31'd0, found}, 32'd1);
    if0.bitready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("stall_valid", {31'd0, if0.bitvalid}, 32'd1);
      check_eq("stall_idx",   {29'd0, if0.bitindex}, 32'd2);
      check_eq("stall_bit",   {31'd0, if0.bitout},   32'd0);
      check_eq("stall_sel",   {29'd0, if0.select},   32'd2);
    end
    if0.bitready = 1'b1;
    tick();
    check_eq("release_sel",   {29'd0, if0.select},   32'd3);
    check_eq("release_valid", {31'd0, if0.bitvalid}, 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (if0.done) begin seen_done = 1'b1; break; end
    end
    check_eq("stall_done", {31'd0, seen_done}, 32'd1);
    tick();

    // Sampling point with SETTLE_CYCLES=3
    if3.bitready = 1'b1;
    ovr_en = 1'b1; ovr_val = 1'b0;
    if3.start = 1'b1;
    tick();                     // edge 1
    if3.start = 1'b0;
    ovr_val = 1'b1;
    tick();                     // edge 2
    check_eq("s3_valid_e2", {31'd0, if3.bitvalid}, 32'd0);
    ovr_val = 1'b1;
    tick();                     // edge 3
    check_eq("s3_valid_e3", {31'd0, if3.bitvalid}, 32'd0);
    ovr_val = 1'b0;
    tick();                     // edge 4: capture
    check_eq("s3_valid_e4", {31'd0, if3.bitvalid}, 32'd1);
    check_eq("s3_bit0",     {31'd0, if3.bitout},   32'd0);
    check_eq("s3_idx0",     {29'd0, if3.bitindex}, 32'd0);
    ovr_val = 1'b1;
    tick();                     // edge 5: transfer
    check_eq("s3_xfer_valid", {31'd0, if3.bitvalid}, 32'd0);
    check_eq("s3_xfer_sel",   {29'd0, if3.select},   32'd1);
    ovr_val = 1'b0;
    tick();                     // edge 6
    ovr_val = 1'b0;
    tick();                     // edge 7
    check_eq("s3_valid_e7", {31'd0, if3.bitvalid}, 32'd0);
    ovr_val = 1'b1;
    tick();                     // edge 8: capture
    check_eq("s3_valid_e8", {31'd0, if3.bitvalid}, 32'd1);
    check_eq("s3_bit1",     {31'd0, if3.bitout},   32'd1);
    check_eq("s3_idx1",     {29'd0, if3.bitindex}, 32'd1);
    ovr_en = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (if3.done) begin seen_done = 1'b1; break; end
    end
    check_eq("s3_done", {31'd0, seen_done}, 32'd1);
    tick();

    // Start held through two scans
    if0.bitready = 1'b1;
    if0.start = 1'b1;
    n = 0; first_done = 0; second_done = 0; ndone = 0;
    for (int i = 0; i < 36; i++) begin
      tick(); n++;
      if (if0.done) begin
        ndone++;
        if (first_done == 0) first_done = n; else second_done = n;
      end
      if (n == 18) begin
        check_eq("held_idle_busy", {31'd0, if0.busy},   32'd0);
        check_eq("held_idle_sel",  {29'd0, if0.select}, 32'd7);
      end
      if (n == 19) begin
        check_eq("held_restart_busy", {31'd0, if0.busy},   32'd1);
        check_eq("held_restart_sel",  {29'd0, if0.select}, 32'd0);
      end
      if (n == 35) if0.start = 1'b0;
    end
    tick(); tick();
    check_eq("held_end_busy", {31'd0, if0.busy}, 32'd0);
    check_eq("held_done1",    first_done,  32'd17);
    check_eq("held_done2",    second_done, 32'd35);
    check_eq("held_ndone",    ndone,       32'd2);

    // Reset mid-scan during SETTLE at index 3
    if3.bitready = 1'b1;
    if3.start = 1'b1;
    tick();
    if3.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (if3.select == 3'd3 && !if3.bitvalid && if3.busy) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check_eq("mid_found", {31'd0, found}, 32'd1);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("mid_sel",   {29'd0, if3.select},   32'd0);
      check_eq("mid_seln",  {29'd0, if3.select_n}, 32'd7);
      check_eq("mid_valid", {31'd0, if3.bitvalid}, 32'd0);
      check_eq("mid_busy",  {31'd0, if3.busy},     32'd0);
      check_eq("mid_done",  {31'd0, if3.done},     32'd0);
    end
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (if3.done) ndone++;
    end
    check_eq("mid_no_done",   ndone,                32'd0);
    check_eq("mid_idle_busy", {31'd0, if3.busy},    32'd0);

    rail_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
